circle_sequencer: RTL and testbench

Parametrised draw sequencer sitting between the VGA adapter and the team's `fillscreen` and `circle` engines. On `start` it optionally clears the screen, then drives the circle engine through `NUM_CIRCLES` concentric circles with stepped radius and cycling colour. It multiplexes the engines' pixel streams onto one VGA port. It supports a single-pass mode and a continuous animation mode, where the colour rotates every pass. The engines are external, connected only through their start/done handshakes and pixel buses, so the block can be benched against stub engines.

---
 rtl/circle_sequencer_if.sv | 58 +++++
 rtl/circle_sequencer.sv | 139 +++++++++++++
 tb/tb_circle_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/circle_sequencer_if.sv
// Signal bundle between circle_sequencer and its surroundings: control, the two
// engine handshakes and pixel buses, and the merged VGA adapter bus.
interface circle_sequencer_if;
  logic       start;
  logic       mode;
  logic       stop;
  logic [2:0] colour_base;
  logic       busy;
  logic       done;
  logic       pass_done;

  logic       fs_start;
  logic [2:0] fs_colour;
  logic       fs_done;
  logic [7:0] fs_vga_x;
  logic [6:0] fs_vga_y;
  logic [2:0] fs_vga_colour;
  logic       fs_vga_plot;

  logic       circ_start;
  logic       circ_done;
  logic [7:0] circ_centre_x;
  logic [6:0] circ_centre_y;
  logic [7:0] circ_radius;
  logic [2:0] circ_colour;
  logic [7:0] circ_vga_x;
  logic [6:0] circ_vga_y;
  logic [2:0] circ_vga_colour;
  logic       circ_vga_plot;

  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;
  logic [3:0] circ_idx;

  // Sequencer side.
  modport master (
    input  start, mode, stop, colour_base,
    input  fs_done, fs_vga_x, fs_vga_y, fs_vga_colour, fs_vga_plot,
    input  circ_done, circ_vga_x, circ_vga_y, circ_vga_colour, circ_vga_plot,
    output busy, done, pass_done,
    output fs_start, fs_colour,
    output circ_start, circ_centre_x, circ_centre_y, circ_radius, circ_colour,
    output vga_x, vga_y, vga_colour, vga_plot, circ_idx
  );

  // Engine / adapter / controller side.
  modport slave (
    output start, mode, stop, colour_base,
    output fs_done, fs_vga_x, fs_vga_y, fs_vga_colour, fs_vga_plot,
    output circ_done, circ_vga_x, circ_vga_y, circ_vga_colour, circ_vga_plot,
    input  busy, done, pass_done,
    input  fs_start, fs_colour,
    input  circ_start, circ_centre_x, circ_centre_y, circ_radius, circ_colour,
    input  vga_x, vga_y, vga_colour, vga_plot, circ_idx
  );
endinterface

// File: rtl/circle_sequencer.sv
// Draw sequencer: optional screen clear, then NUM_CIRCLES concentric circles with
// stepped radius and cycling colour; single-pass or continuous animation.
module circle_sequencer #(
  parameter int         NUM_CIRCLES = 4,
  parameter logic [7:0] CENTRE_X    = 8'd80,
  parameter logic [6:0] CENTRE_Y    = 7'd60,
  parameter int         RADIUS_BASE = 10,
  parameter int         RADIUS_STEP = 10,
  parameter logic [2:0] BG_COLOUR   = 3'b000,
  parameter int         CLEAR_EN    = 1
) (
  input logic                clk,
  input logic                rst,
  circle_sequencer_if.master bus
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_CLEAR      = 3'd1;
  localparam logic [2:0] S_WAIT_CLEAR = 3'd2;
  localparam logic [2:0] S_DRAW       = 3'd3;
  localparam logic [2:0] S_WAIT_DRAW  = 3'd4;
  localparam logic [2:0] S_DONE       = 3'd5;

  localparam logic [2:0] S_FIRST  = (CLEAR_EN != 0) ? S_CLEAR : S_DRAW;
  localparam logic [3:0] LAST_IDX = 4'(NUM_CIRCLES - 1);
  localparam logic [7:0] RADIUS0  = (RADIUS_BASE > 255) ? 8'hFF : 8'(RADIUS_BASE);

  logic [2:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [2:0]  cbase_q, cbase_d;
  logic        mode_q, mode_d;
  logic        pass_done_q, pass_done_d;
  logic [7:0]  radius_q, radius_d;
  logic [2:0]  colour_q, colour_d;
  logic [15:0] radius_full;
  logic        last_circle;

  assign last_circle = (idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cbase_d     = cbase_q;
    mode_d      = mode_q;
    pass_done_d = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_FIRST;
          idx_d   = 4'd0;
          cbase_d = bus.colour_base;
          mode_d  = bus.mode;
        end
      end
      S_CLEAR:      state_d = S_WAIT_CLEAR;
      S_WAIT_CLEAR: if (bus.fs_done) state_d = S_DRAW;
      S_DRAW:       state_d = S_WAIT_DRAW;
      S_WAIT_DRAW: begin
        if (bus.circ_done) begin
          if (!last_circle) begin
            idx_d   = idx_q + 4'd1;
            state_d = S_DRAW;
          end else begin
            pass_done_d = 1'b1;
            // stop only matters at a pass boundary, and only when animating
            if (mode_q && !bus.stop) begin
              idx_d   = 4'd0;
              cbase_d = cbase_q + 3'd1;
              state_d = S_FIRST;
            end else begin
              state_d = S_DONE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Radius/colour follow the next index so they are already valid in the DRAW cycle.
  assign radius_full = 16'(RADIUS_BASE) + 16'(idx_d) * 16'(RADIUS_STEP);
  assign radius_d    = (radius_full > 16'd255) ? 8'hFF : radius_full[7:0];
  assign colour_d    = cbase_d + idx_d[2:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 4'd0;
      cbase_q     <= 3'd0;
      mode_q      <= 1'b0;
      pass_done_q <= 1'b0;
      radius_q    <= RADIUS0;
      colour_q    <= 3'd0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cbase_q     <= cbase_d;
      mode_q      <= mode_d;
      pass_done_q <= pass_done_d;
      radius_q    <= radius_d;
      colour_q    <= colour_d;
    end
  end

  assign bus.busy          = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done          = (state_q == S_DONE);
  assign bus.pass_done     = pass_done_q;
  assign bus.fs_start      = (state_q == S_CLEAR);
  assign bus.fs_colour     = BG_COLOUR;
  assign bus.circ_start    = (state_q == S_DRAW);
  assign bus.circ_centre_x = CENTRE_X;
  assign bus.circ_centre_y = CENTRE_Y;
  assign bus.circ_radius   = radius_q;
  assign bus.circ_colour   = colour_q;
  assign bus.circ_idx      = idx_q;

  always_comb begin
    bus.vga_x      = 8'd0;
    bus.vga_y      = 7'd0;
    bus.vga_colour = 3'd0;
    bus.vga_plot   = 1'b0;
    case (state_q)
      S_CLEAR, S_WAIT_CLEAR: begin
        bus.vga_x      = bus.fs_vga_x;
        bus.vga_y      = bus.fs_vga_y;
        bus.vga_colour = bus.fs_vga_colour;
        bus.vga_plot   = bus.fs_vga_plot;
      end
      S_DRAW, S_WAIT_DRAW: begin
        bus.vga_x      = bus.circ_vga_x;
        bus.vga_y      = bus.circ_vga_y;
        bus.vga_colour = bus.circ_vga_colour;
        bus.vga_plot   = bus.circ_vga_plot;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_circle_sequencer.sv
// Bench for circle_sequencer: two instances (default, and saturating radius without
// clear) driven by stub engines that answer done 5 cycles after their start.
module tb_circle_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  circle_sequencer_if bus_a ();
  circle_sequencer_if bus_b ();

  circle_sequencer dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  circle_sequencer #(.RADIUS_BASE(200), .RADIUS_STEP(40), .CLEAR_EN(0))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  int n_cmp = 0;
  int n_fail = 0;

  // Stub engines: done pulses one cycle, five cycles after the start strobe.
  int   fs_cnt_a = 0, circ_cnt_a = 0, circ_cnt_b = 0;
  logic fs_done_a = 1'b0, circ_done_a = 1'b0, circ_done_b = 1'b0, spur_a = 1'b0;
  assign bus_a.fs_done   = fs_done_a;
  assign bus_a.circ_done = circ_done_a | spur_a;
  assign bus_b.fs_done   = 1'b0;
  assign bus_b.circ_done = circ_done_b;

  always @(posedge clk) begin
    if (rst) begin
      fs_cnt_a <= 0; circ_cnt_a <= 0; circ_cnt_b <= 0;
      fs_done_a <= 1'b0; circ_done_a <= 1'b0; circ_done_b <= 1'b0;
    end else begin
      fs_done_a <= 1'b0; circ_done_a <= 1'b0; circ_done_b <= 1'b0;
      if (fs_cnt_a != 0) begin
        fs_cnt_a <= fs_cnt_a - 1;
        if (fs_cnt_a == 1) fs_done_a <= 1'b1;
      end else if (bus_a.fs_start) fs_cnt_a <= 5;
      if (circ_cnt_a != 0) begin
        circ_cnt_a <= circ_cnt_a - 1;
        if (circ_cnt_a == 1) circ_done_a <= 1'b1;
      end else if (bus_a.circ_start) circ_cnt_a <= 5;
      if (circ_cnt_b != 0) begin
        circ_cnt_b <= circ_cnt_b - 1;
        if (circ_cnt_b == 1) circ_done_b <= 1'b1;
      end else if (bus_b.circ_start) circ_cnt_b <= 5;
    end
  end

  // Protocol-level tracker of which engine owns the pixel bus on instance A.
  int phase_a = 0;  // 0 none, 1 fill engine, 2 circle engine
  always @(posedge clk) begin
    if (rst) phase_a <= 0;
    else if (bus_a.fs_start) phase_a <= 1;
    else if (bus_a.circ_start) phase_a <= 2;
    else if ((phase_a == 1 && bus_a.fs_done) || (phase_a == 2 && bus_a.circ_done)) phase_a <= 0;
  end

  // Event counters and per-circle logs captured at each circ_start.
  int nfs_a = 0, ncs_a = 0, npd_a = 0, npdd_a = 0, nlog_a = 0;
  int nfs_b = 0, ncs_b = 0, npd_b = 0, nlog_b = 0;
  logic [7:0] rad_log_a [64];
  logic [2:0] col_log_a [64];
  logic [3:0] idx_log_a [64];
  logic [7:0] rad_log_b [64];
  logic [2:0] col_log_b [64];

  always @(negedge clk) begin
    if (bus_a.fs_start) nfs_a <= nfs_a + 1;
    if (bus_a.pass_done) npd_a <= npd_a + 1;
    if (bus_a.pass_done && bus_a.done) npdd_a <= npdd_a + 1;
    if (bus_a.circ_start) begin
      ncs_a <= ncs_a + 1;
      rad_log_a[nlog_a[5:0]] <= bus_a.circ_radius;
      col_log_a[nlog_a[5:0]] <= bus_a.circ_colour;
      idx_log_a[nlog_a[5:0]] <= bus_a.circ_idx;
      nlog_a <= nlog_a + 1;
    end
    if (bus_b.fs_start) nfs_b <= nfs_b + 1;
    if (bus_b.pass_done) npd_b <= npd_b + 1;
    if (bus_b.circ_start) begin
      ncs_b <= ncs_b + 1;
      rad_log_b[nlog_b[5:0]] <= bus_b.circ_radius;
      col_log_b[nlog_b[5:0]] <= bus_b.circ_colour;
      nlog_b <= nlog_b + 1;
    end
  end

  function automatic logic [7:0] exp_radius(input int base, input int step, input int i);
    int r;
    r = base + i * step;
    return (r > 255) ? 8'd255 : 8'(r);
  endfunction

  task automatic pulse_start(input bit use_b, input logic [2:0] cb, input bit md);
    if (use_b) begin
      bus_b.start = 1'b1; bus_b.colour_base = cb; bus_b.mode = md;
    end else begin
      bus_a.start = 1'b1; bus_a.colour_base = cb; bus_a.mode = md;
    end
    @(negedge clk);
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
  endtask

  task automatic wait_done(input bit use_b, input int budget);
    int k;
    k = 0;
    while (((use_b ? bus_b.done : bus_a.done) !== 1'b1) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= budget) begin
      n_fail++;
      $display("FAIL wait_done inst=%0d: done not seen within %0d cycles", use_b, budget);
    end
    #1;
  endtask

  task automatic test_reset();
    logic [27:0] obs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    obs = {bus_a.busy, bus_a.done, bus_a.pass_done, bus_a.fs_start, bus_a.circ_start,
           bus_a.vga_plot, bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour, bus_a.circ_idx};
    n_cmp++;
    if (obs !== 28'd0) begin
      n_fail++; $display("FAIL reset_a: outputs=%h expected 0", obs);
    end
    obs = {bus_b.busy, bus_b.done, bus_b.pass_done, bus_b.fs_start, bus_b.circ_start,
           bus_b.vga_plot, bus_b.vga_x, bus_b.vga_y, bus_b.vga_colour, bus_b.circ_idx};
    n_cmp++;
    if (obs !== 28'd0) begin
      n_fail++; $display("FAIL reset_b: outputs=%h expected 0", obs);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single(input logic [2:0] cb);
    int lb, f0, c0, p0, pd0;
    logic [2:0] ecol;
    lb = nlog_a; f0 = nfs_a; c0 = ncs_a; p0 = npd_a; pd0 = npdd_a;
    pulse_start(1'b0, cb, 1'b0);
    n_cmp++;
    if ({bus_a.fs_start, bus_a.busy, bus_a.circ_start} !== 3'b110) begin
      n_fail++;
      $display("FAIL clear_cycle: fs_start/busy/circ_start=%b expected 110",
               {bus_a.fs_start, bus_a.busy, bus_a.circ_start});
    end
    // start while busy, with different settings, must be ignored
    repeat (3) @(negedge clk);
    pulse_start(1'b0, ~cb, 1'b1);
    wait_done(1'b0, 400);
    n_cmp++;
    if (nfs_a - f0 != 1 || ncs_a - c0 != 4 || npd_a - p0 != 1 || npdd_a - pd0 != 1) begin
      n_fail++;
      $display("FAIL single_counts cb=%0d: fs=%0d circ=%0d pass_done=%0d with_done=%0d expected 1 4 1 1",
               cb, nfs_a - f0, ncs_a - c0, npd_a - p0, npdd_a - pd0);
    end
    for (int i = 0; i < 4; i++) begin
      ecol = cb + 3'(i);
      n_cmp++;
      if (rad_log_a[6'(lb + i)] !== exp_radius(10, 10, i) || col_log_a[6'(lb + i)] !== ecol
          || idx_log_a[6'(lb + i)] !== 4'(i)) begin
        n_fail++;
        $display("FAIL single_circle cb=%0d i=%0d: radius=%0d colour=%0d idx=%0d expected %0d %0d %0d",
                 cb, i, rad_log_a[6'(lb + i)], col_log_a[6'(lb + i)], idx_log_a[6'(lb + i)],
                 exp_radius(10, 10, i), ecol, i);
      end
    end
    $display("single pass cb=%0d finished, done=%0b busy=%0b", cb, bus_a.done, bus_a.busy);
  endtask

  task automatic test_continuous_sat();
    int lb, f0, c0, p0, k;
    logic [2:0] cb, ecol;
    cb = 3'd3;
    lb = nlog_b; f0 = nfs_b; c0 = ncs_b; p0 = npd_b;
    pulse_start(1'b1, cb, 1'b1);
    k = 0;
    while (npd_b - p0 < 2 && k < 1000) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_cmp++;
    if (k >= 1000) begin
      n_fail++; $display("FAIL cont_two_passes: saw %0d pass_done expected 2", npd_b - p0);
    end
    repeat ($urandom_range(0, 8)) @(negedge clk);
    bus_b.stop = 1'b1;
    wait_done(1'b1, 400);
    bus_b.stop = 1'b0;
    n_cmp++;
    if (npd_b - p0 != 3 || nfs_b - f0 != 0 || ncs_b - c0 != 12 || bus_b.done !== 1'b1) begin
      n_fail++;
      $display("FAIL cont_counts: pass_done=%0d fs=%0d circ=%0d done=%0b expected 3 0 12 1",
               npd_b - p0, nfs_b - f0, ncs_b - c0, bus_b.done);
    end
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 4; i++) begin
        ecol = cb + 3'(p) + 3'(i);
        n_cmp++;
        if (rad_log_b[6'(lb + 4 * p + i)] !== exp_radius(200, 40, i)
            || col_log_b[6'(lb + 4 * p + i)] !== ecol) begin
          n_fail++;
          $display("FAIL cont_circle p=%0d i=%0d: radius=%0d colour=%0d expected %0d %0d",
                   p, i, rad_log_b[6'(lb + 4 * p + i)], col_log_b[6'(lb + 4 * p + i)],
                   exp_radius(200, 40, i), ecol);
        end
      end
    end
    $display("continuous run finished after %0d passes", npd_b - p0);
  endtask

  task automatic test_mux();
    int c0, k, bad;
    logic [18:0] exp_v, obs_v, fs_v, ci_v;
    c0 = ncs_a; bad = 0;
    pulse_start(1'b0, 3'($urandom), 1'b0);
    k = 0;
    while (k < 400) begin
      bus_a.fs_vga_x = 8'($urandom); bus_a.fs_vga_y = 7'($urandom);
      bus_a.fs_vga_colour = 3'($urandom); bus_a.fs_vga_plot = 1'($urandom);
      bus_a.circ_vga_x = 8'($urandom); bus_a.circ_vga_y = 7'($urandom);
      bus_a.circ_vga_colour = 3'($urandom); bus_a.circ_vga_plot = 1'($urandom);
      spur_a = (phase_a == 1);
      #1;
      fs_v = {bus_a.fs_vga_plot, bus_a.fs_vga_x, bus_a.fs_vga_y, bus_a.fs_vga_colour};
      ci_v = {bus_a.circ_vga_plot, bus_a.circ_vga_x, bus_a.circ_vga_y, bus_a.circ_vga_colour};
      if (bus_a.busy !== 1'b1) exp_v = 19'd0;
      else if (bus_a.fs_start === 1'b1 || phase_a == 1) exp_v = fs_v;
      else if (bus_a.circ_start === 1'b1 || phase_a == 2) exp_v = ci_v;
      else exp_v = 19'd0;
      obs_v = {bus_a.vga_plot, bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour};
      n_cmp++;
      if (obs_v !== exp_v) begin
        n_fail++; bad++;
        if (bad < 5) $display("FAIL mux cycle=%0d phase=%0d: vga=%h expected %h", k, phase_a, obs_v, exp_v);
      end
      if (bus_a.done === 1'b1) break;
      @(negedge clk);
      k++;
    end
    spur_a = 1'b0;
    n_cmp++;
    if (k >= 400 || ncs_a - c0 != 4) begin
      n_fail++; $display("FAIL mux_run: cycles=%0d circ_starts=%0d expected done and 4", k, ncs_a - c0);
    end
    $display("mux run checked over %0d cycles", k);
  endtask

  task automatic test_reset_mid();
    int k, lb;
    logic [27:0] obs;
    logic [2:0] cb;
    cb = 3'($urandom);
    pulse_start(1'b0, 3'd2, 1'b0);
    k = 0;
    while (!(bus_a.circ_idx === 4'd2 && bus_a.busy === 1'b1 && bus_a.circ_start === 1'b0) && k < 400) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k >= 400) begin
      n_fail++; $display("FAIL reset_mid_reach: circle 2 wait state not reached, idx=%0d", bus_a.circ_idx);
    end
    rst = 1'b1;
    @(negedge clk);
    obs = {bus_a.busy, bus_a.done, bus_a.pass_done, bus_a.fs_start, bus_a.circ_start,
           bus_a.vga_plot, bus_a.vga_x, bus_a.vga_y, bus_a.vga_colour, bus_a.circ_idx};
    n_cmp++;
    if (obs !== 28'd0) begin
      n_fail++; $display("FAIL reset_mid: outputs=%h expected 0", obs);
    end
    rst = 1'b0;
    @(negedge clk);
    #1;
    lb = nlog_a;
    pulse_start(1'b0, cb, 1'b0);
    wait_done(1'b0, 400);
    n_cmp++;
    if (nlog_a - lb != 4 || idx_log_a[6'(lb)] !== 4'd0 || rad_log_a[6'(lb)] !== 8'd10
        || col_log_a[6'(lb)] !== cb) begin
      n_fail++;
      $display("FAIL restart: circles=%0d first idx=%0d radius=%0d colour=%0d expected 4 0 10 %0d",
               nlog_a - lb, idx_log_a[6'(lb)], rad_log_a[6'(lb)], col_log_a[6'(lb)], cb);
    end
    $display("restart after mid-run reset finished, cb=%0d", cb);
  endtask

  initial begin
    bus_a.start = 1'b0; bus_a.mode = 1'b0; bus_a.stop = 1'b0; bus_a.colour_base = 3'd0;
    bus_b.start = 1'b0; bus_b.mode = 1'b0; bus_b.stop = 1'b0; bus_b.colour_base = 3'd0;
    bus_a.fs_vga_x = 8'h11; bus_a.fs_vga_y = 7'h22; bus_a.fs_vga_colour = 3'd1; bus_a.fs_vga_plot = 1'b1;
    bus_a.circ_vga_x = 8'h33; bus_a.circ_vga_y = 7'h44; bus_a.circ_vga_colour = 3'd5; bus_a.circ_vga_plot = 1'b1;
    bus_b.fs_vga_x = 8'd0; bus_b.fs_vga_y = 7'd0; bus_b.fs_vga_colour = 3'd0; bus_b.fs_vga_plot = 1'b0;
    bus_b.circ_vga_x = 8'h55; bus_b.circ_vga_y = 7'h66; bus_b.circ_vga_colour = 3'd2; bus_b.circ_vga_plot = 1'b1;
    @(negedge clk);
    test_reset();
    test_single(3'd3);
    test_single(3'd6);
    test_single(3'($urandom));
    test_continuous_sat();
    test_mux();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
